// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FSM-controlled FIFO.
// Holds the occupancy-state encoding, the request decode and the parameter defaults.
package fifo_pkg;

    localparam int DEF_WORD_LENGTH   = 8;
    localparam int DEF_NUM_OF_WORDS  = 32;
    localparam int DEF_POINTER_WIDTH = 5;
    localparam int DEF_AFULL_THRESH  = 28;
    localparam int DEF_AEMPTY_THRESH = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        PARTIAL = 2'b01,
        FULL    = 2'b10
    } occ_state_t;

    // Bit order matches {write_to_stack, read_from_stack}.
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        READ_ONLY  = 2'b01,
        WRITE_ONLY = 2'b10,
        BOTH       = 2'b11
    } op_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: one synchronous write port and one
// synchronous read port whose output register holds while rd_en is low.
module fifo_ram #(
    parameter int WORD_LENGTH   = 8,
    parameter int NUM_OF_WORDS  = 32,
    parameter int POINTER_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [POINTER_WIDTH-1:0] wr_addr,
    input  logic [WORD_LENGTH-1:0]   wr_data,
    input  logic                     rd_en,
    input  logic [POINTER_WIDTH-1:0] rd_addr,
    output logic [WORD_LENGTH-1:0]   rd_data
);

    logic [WORD_LENGTH-1:0] mem [NUM_OF_WORDS];

    // NOTE: storage has no reset so it maps onto plain RAM; the control logic
    // decides which entries are meaningful, so stale contents are never visible.
    // NOTE: non-blocking assignments give read-before-write on a same-address
    // read and write, which the full-FIFO simultaneous read/write relies on.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_fsm_param.sv
// Parameterised FIFO with an EMPTY/PARTIAL/FULL occupancy FSM and registered flags.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo_fsm_param
    import fifo_pkg::*;
#(
    parameter int WORD_LENGTH   = DEF_WORD_LENGTH,
    parameter int NUM_OF_WORDS  = DEF_NUM_OF_WORDS,
    parameter int POINTER_WIDTH = DEF_POINTER_WIDTH,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WORD_LENGTH-1:0]   data_in,
    input  logic                     write_to_stack,
    input  logic                     read_from_stack,
    output logic [WORD_LENGTH-1:0]   data_out,
    output logic                     stack_full,
    output logic                     stack_empty,
    output logic                     almost_full,
    output logic                     almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                     overflow,
    output logic                     underflow,
`endif
    output logic [POINTER_WIDTH:0]   word_count
);

    localparam logic [POINTER_WIDTH:0] DEPTH_CNT  = (POINTER_WIDTH+1)'(NUM_OF_WORDS);
    localparam logic [POINTER_WIDTH:0] AFULL_CNT  = (POINTER_WIDTH+1)'(AFULL_THRESH);
    localparam logic [POINTER_WIDTH:0] AEMPTY_CNT = (POINTER_WIDTH+1)'(AEMPTY_THRESH);

    occ_state_t                 state;
    occ_state_t                 next_state;
    op_t                        op;
    logic                       wr_accept;
    logic                       rd_accept;
    logic [POINTER_WIDTH:0]     next_count;
    logic [POINTER_WIDTH-1:0]   wr_ptr;
    logic [POINTER_WIDTH-1:0]   rd_ptr;
    logic [WORD_LENGTH-1:0]     ram_rd_data;
    logic                       out_valid;

    assign op = op_t'({write_to_stack, read_from_stack});

    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        wr_accept  = 1'b0;
        rd_accept  = 1'b0;
        next_state = state;
        next_count = word_count;

        unique case (state)
            EMPTY: begin
                wr_accept = (op == WRITE_ONLY) || (op == BOTH);
            end
            PARTIAL: begin
                wr_accept = (op == WRITE_ONLY) || (op == BOTH);
                rd_accept = (op == READ_ONLY)  || (op == BOTH);
            end
            FULL: begin
                // A simultaneous read frees the slot the write lands in.
                wr_accept = (op == BOTH);
                rd_accept = (op == READ_ONLY) || (op == BOTH);
            end
            default: begin
                next_state = EMPTY;
            end
        endcase

        case ({wr_accept, rd_accept})
            2'b10:   next_count = word_count + 1'b1;
            2'b01:   next_count = word_count - 1'b1;
            default: next_count = word_count;
        endcase

        unique case (state)
            EMPTY: begin
                if (wr_accept) begin
                    next_state = PARTIAL;
                end
            end
            PARTIAL: begin
                if (next_count == DEPTH_CNT) begin
                    next_state = FULL;
                end else if (next_count == '0) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (rd_accept && !wr_accept) begin
                    next_state = PARTIAL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Pointers, count and flags; flags are registered from the next count so
    // they line up with word_count on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            word_count   <= '0;
            stack_full   <= 1'b0;
            stack_empty  <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            out_valid    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr    <= rd_ptr + 1'b1;
                out_valid <= 1'b1;
            end
            word_count   <= next_count;
            stack_full   <= (next_count == DEPTH_CNT);
            stack_empty  <= (next_count == '0);
            almost_full  <= (next_count >= AFULL_CNT);
            almost_empty <= (next_count <= AEMPTY_CNT);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_to_stack && !wr_accept) begin
                overflow <= 1'b1;
            end
            if (read_from_stack && !rd_accept) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    fifo_ram #(
        .WORD_LENGTH  (WORD_LENGTH),
        .NUM_OF_WORDS (NUM_OF_WORDS),
        .POINTER_WIDTH(POINTER_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_accept),
        .wr_addr(wr_ptr),
        .wr_data(data_in),
        .rd_en  (rd_accept),
        .rd_addr(rd_ptr),
        .rd_data(ram_rd_data)
    );

    // The RAM read register cannot be reset, so data_out reads as zero until
    // the first accepted read after reset reloads it.
    assign data_out = out_valid ? ram_rd_data : '0;

endmodule

// File: tb/tb_fifo_fsm_param.sv
// Self-checking bench for fifo_fsm_param: vector table plus queue model/scoreboard.
// Checks overflow/underflow as well when built with FIFO_ERR_FLAGS_EN.
module tb_fifo_fsm_param;

    localparam int W      = 8;
    localparam int D      = 32;
    localparam int PW     = 5;
    localparam int AFULL  = 28;
    localparam int AEMPTY = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  data_in;
    logic          wr;
    logic          rd;
    logic [W-1:0]  data_out;
    logic          stack_full;
    logic          stack_empty;
    logic          almost_full;
    logic          almost_empty;
    logic [PW:0]   word_count;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    fifo_fsm_param #(
        .WORD_LENGTH  (W),
        .NUM_OF_WORDS (D),
        .POINTER_WIDTH(PW),
        .AFULL_THRESH (AFULL),
        .AEMPTY_THRESH(AEMPTY)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .write_to_stack (wr),
        .read_from_stack(rd),
        .data_out       (data_out),
        .stack_full     (stack_full),
        .stack_empty    (stack_empty),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow       (overflow),
        .underflow      (underflow),
`endif
        .word_count     (word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mdl_q [$];
    logic [W-1:0] sb_q  [$];
    logic [W-1:0] exp_dout;
    bit           exp_ovf;
    bit           exp_udf;

    typedef struct {
        logic         w;
        logic         r;
        logic [W-1:0] d;
        int           cnt;
        logic         empty;
        logic [W-1:0] dout;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = mdl_q.size();
        check({tag, " word_count"},   word_count,   n);
        check({tag, " stack_empty"},  stack_empty,  n == 0);
        check({tag, " stack_full"},   stack_full,   n == D);
        check({tag, " almost_full"},  almost_full,  n >= AFULL);
        check({tag, " almost_empty"}, almost_empty, n <= AEMPTY);
`ifdef FIFO_ERR_FLAGS_EN
        check({tag, " overflow"},  overflow,  exp_ovf);
        check({tag, " underflow"}, underflow, exp_udf);
`endif
    endtask

    // One clock of stimulus: the model decides acceptance, expected read data
    // goes into the scoreboard, and outputs are compared 1 time unit after the edge.
    task automatic step(input logic w, input logic r, input logic [W-1:0] d, input string tag);
        int n;
        bit wacc;
        bit racc;
        @(negedge clk);
        wr      = w;
        rd      = r;
        data_in = d;
        n    = mdl_q.size();
        racc = r && (n != 0);
        wacc = w && ((n < D) || racc);
        if (racc) sb_q.push_back(mdl_q.pop_front());
        if (wacc) mdl_q.push_back(d);
        exp_ovf = exp_ovf | (w && !wacc);
        exp_udf = exp_udf | (r && !racc);
        @(posedge clk);
        #1;
        if (racc) begin
            if (sb_q.size() == 0) begin
                check({tag, " scoreboard_empty"}, 1, 0);
            end else begin
                exp_dout = sb_q.pop_front();
            end
        end
        check({tag, " data_out"}, data_out, exp_dout);
        check_state(tag);
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic clear_model();
        mdl_q.delete();
        sb_q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    // Reset lands between clock edges; outputs must settle without an edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        clear_model();
        check({tag, " data_out"}, data_out, 0);
        check_state(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'd1,  1, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 1'b0, 8'd10, 2, 1'b0, 8'd0};
        vecs[2] = '{1'b1, 1'b0, 8'd20, 3, 1'b0, 8'd0};
        vecs[3] = '{1'b0, 1'b1, 8'd0,  2, 1'b0, 8'd1};
        vecs[4] = '{1'b0, 1'b1, 8'd0,  1, 1'b0, 8'd10};
        vecs[5] = '{1'b0, 1'b1, 8'd0,  0, 1'b1, 8'd20};
        vecs[6] = '{1'b1, 1'b1, 8'd42, 1, 1'b0, 8'd20};
        vecs[7] = '{1'b0, 1'b1, 8'd0,  0, 1'b1, 8'd42};
        vecs[8] = '{1'b0, 1'b1, 8'd0,  0, 1'b1, 8'd42};
        vecs[9] = '{1'b0, 1'b0, 8'd0,  0, 1'b1, 8'd42};

        reset   = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        data_in = '0;
        clear_model();
        #2;
        check("reset data_out", data_out, 0);
        check_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // Basic order, BOTH on empty and a rejected read, from the table.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].w, vecs[i].r, vecs[i].d, $sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl_count", i), word_count, vecs[i].cnt);
            check($sformatf("vec%0d tbl_empty", i), stack_empty, vecs[i].empty);
            check($sformatf("vec%0d tbl_dout", i), data_out, vecs[i].dout);
        end

        // Fill to full: almost_full from the 28th write, full at the 32nd.
        for (int i = 0; i < D; i++) begin
            step(1'b1, 1'b0, W'(i * 3 + 5), $sformatf("fill%0d", i));
            check($sformatf("fill%0d afull", i), almost_full, (i + 1) >= AFULL);
            check($sformatf("fill%0d full", i), stack_full, (i + 1) == D);
        end
        step(1'b1, 1'b0, 8'd200, "overwrite");
        check("overwrite count", word_count, D);

        // BOTH while full: oldest word out, 99 queued at the back.
        step(1'b1, 1'b1, 8'd99, "both_full");
        check("both_full dout", data_out, 5);
        check("both_full count", word_count, D);
        for (int i = 0; i < D - 1; i++) begin
            step(1'b0, 1'b1, 8'd0, $sformatf("drain%0d", i));
        end
        step(1'b0, 1'b1, 8'd0, "drain_last");
        check("drain_last dout", data_out, 99);
        check("drain_last empty", stack_empty, 1);

        // BOTH while empty: only the write is taken, data_out holds.
        step(1'b1, 1'b1, 8'd42, "both_empty");
        check("both_empty count", word_count, 1);
        check("both_empty dout", data_out, 99);
        step(1'b0, 1'b1, 8'd0, "read42");
        check("read42 dout", data_out, 42);
        step(1'b0, 1'b1, 8'd0, "read_empty");
        check("read_empty count", word_count, 0);

        // Pointer wrap: keep a few words resident while 40 pairs stream through.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, W'(i + 150), $sformatf("pre%0d", i));
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, W'(i * 7 + 13), $sformatf("pair_w%0d", i));
            step(1'b0, 1'b1, 8'd0, $sformatf("pair_r%0d", i));
        end
        check("wrap count", word_count, 3);

        // Reset in the middle of a burst, then confirm normal operation resumes.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, W'(i + 60), $sformatf("burst%0d", i));
        end
        async_reset("mid_reset");
        step(1'b1, 1'b0, 8'd77, "post_w");
        step(1'b0, 1'b1, 8'd0, "post_r");
        check("post_r dout", data_out, 77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
